// File: rtl/alu_req_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
// Requester i uses bit i of the valid/ready vectors and slice i of the packed payloads.
interface alu_req_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*OP_W-1:0]   req_opcode;
    logic [2*DATA_W-1:0] req_num_1;
    logic [2*DATA_W-1:0] req_num_2;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [DATA_W-1:0]   resp_ans;
    logic                resp_err;

    modport master (
        output req_valid, req_opcode, req_num_1, req_num_2, resp_ready,
        input  req_ready, resp_valid, resp_ans, resp_err
    );

    modport slave (
        input  req_valid, req_opcode, req_num_1, req_num_2, resp_ready,
        output req_ready, resp_valid, resp_ans, resp_err
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// state | meaning
// IDLE  | waiting for a request; grant and accept happen here
// EXEC  | ALU inputs stable, ALU registers its result at the closing edge
// CAPT  | copy ALU result into the response register, park the ALU opcode
// RESP  | response valid to the owner, held until the owner accepts
module alu_req_arbiter #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_req_arbiter_if.slave  bus,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_num_1,
    output logic [DATA_W-1:0] alu_num_2,
    input  logic [DATA_W-1:0] alu_ans,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] resp_ans_q, resp_ans_d;
    logic              resp_err_q, resp_err_d;
    logic [OP_W-1:0]   alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0] alu_num_1_q, alu_num_1_d;
    logic [DATA_W-1:0] alu_num_2_q, alu_num_2_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic              grant;
    logic              any_valid;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_num_1;
    logic [DATA_W-1:0] sel_num_2;
    logic              op_legal;

    // With both requesting, the one not served last wins.
    always_comb begin
        any_valid = |bus.req_valid;
        grant     = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
        sel_op    = grant ? bus.req_opcode[2*OP_W-1:OP_W]   : bus.req_opcode[OP_W-1:0];
        sel_num_1 = grant ? bus.req_num_1[2*DATA_W-1:DATA_W] : bus.req_num_1[DATA_W-1:0];
        sel_num_2 = grant ? bus.req_num_2[2*DATA_W-1:DATA_W] : bus.req_num_2[DATA_W-1:0];
        op_legal  = (sel_op == OP_W'(1)) || (sel_op == OP_W'(2)) ||
                    (sel_op == OP_W'(4)) || (sel_op == OP_W'(8));
    end

    always_comb begin
        bus.req_ready = 2'b00;
        if (state_q == IDLE && any_valid) begin
            bus.req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        resp_ans_d   = resp_ans_q;
        resp_err_d   = resp_err_q;
        alu_opcode_d = alu_opcode_q;
        alu_num_1_d  = alu_num_1_q;
        alu_num_2_d  = alu_num_2_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    last_grant_d = grant;
                    owner_d      = grant;
                    if (op_legal) begin
                        alu_opcode_d = sel_op;
                        alu_num_1_d  = sel_num_1;
                        alu_num_2_d  = sel_num_2;
                        state_d      = EXEC;
                    end else begin
                        resp_ans_d = '1;
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                resp_ans_d   = alu_ans;
                resp_err_d   = 1'b0;
                alu_opcode_d = '0;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready[owner_q]) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            resp_ans_q   <= '0;
            resp_err_q   <= 1'b0;
            alu_opcode_q <= '0;
            alu_num_1_q  <= '0;
            alu_num_2_q  <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            resp_ans_q   <= resp_ans_d;
            resp_err_q   <= resp_err_d;
            alu_opcode_q <= alu_opcode_d;
            alu_num_1_q  <= alu_num_1_d;
            alu_num_2_q  <= alu_num_2_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        bus.resp_valid = 2'b00;
        if (state_q == RESP) begin
            bus.resp_valid = owner_q ? 2'b10 : 2'b01;
        end
        bus.resp_ans = resp_ans_q;
        bus.resp_err = resp_err_q;
        alu_opcode   = alu_opcode_q;
        alu_num_1    = alu_num_1_q;
        alu_num_2    = alu_num_2_q;
        busy         = (state_q != IDLE);
        op_count     = op_count_q;
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: vector table plus hand sequences for arbitration,
// backpressure and mid-operation reset; responses checked through a scoreboard queue.
module tb_alu_req_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_num_1;
    logic [7:0]  alu_num_2;
    logic [7:0]  alu_ans;
    logic        busy;
    logic [15:0] op_count;

    alu_req_arbiter_if #(.DATA_W(8), .OP_W(4)) bus ();

    alu_req_arbiter #(.DATA_W(8), .OP_W(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_num_1  (alu_num_1),
        .alu_num_2  (alu_num_2),
        .alu_ans    (alu_ans),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU stand-in
    always @(posedge clk) begin
        case (alu_opcode)
            4'd1:    alu_ans <= alu_num_1 + alu_num_2;
            4'd2:    alu_ans <= alu_num_1 - alu_num_2;
            4'd4:    alu_ans <= alu_num_1[3:0] * alu_num_2[3:0];
            4'd8:    alu_ans <= alu_num_1 % 8'd3;
            default: alu_ans <= 8'hFF;
        endcase
    end

    typedef struct {
        logic [1:0] who;
        logic [7:0] ans;
        logic       err;
        int         lat;
    } exp_t;

    typedef struct {
        int         who;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ans;
        logic       err;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic [1:0] prev_rv = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (bus.req_valid == 2'b11) chk("ready_onehot", {31'd0, bus.req_ready == 2'b11}, 32'd0);
            if ((bus.req_valid & bus.req_ready) != 2'b00) acc_cyc = cyc;
            if (bus.resp_valid != 2'b00 && prev_rv == 2'b00 && sb.size() > 0)
                chk("latency", cyc - acc_cyc, sb[0].lat);
            if ((bus.resp_valid & bus.resp_ready) != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", {30'd0, bus.resp_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner", {30'd0, bus.resp_valid}, {30'd0, e.who});
                    chk("resp_ans", {24'd0, bus.resp_ans}, {24'd0, e.ans});
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
                end
            end
        end
        prev_rv = bus.resp_valid;
    end

    function automatic exp_t mk_exp(input int who, input logic [7:0] ans, input logic err);
        exp_t e;
        e.who = (who == 1) ? 2'b10 : 2'b01;
        e.ans = ans;
        e.err = err;
        e.lat = err ? 1 : 3;
        return e;
    endfunction

    task automatic set_payload(input int who, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_opcode[who*4 +: 4] = op;
        bus.req_num_1[who*8 +: 8]  = a;
        bus.req_num_2[who*8 +: 8]  = b;
    endtask

    // Returns at the negedge after the accepting posedge, with valid dropped.
    task automatic issue(input int who, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ans, input logic err);
        bit ok = 0;
        @(negedge clk);
        set_payload(who, op, a, b);
        bus.req_valid[who] = 1'b1;
        sb.push_back(mk_exp(who, ans, err));
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            if (bus.req_ready[who]) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
        bus.req_valid[who] = 1'b0;
        if (!ok) begin
            timeout("accept");
            void'(sb.pop_back());
        end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int n = 0; n < 80; n++) begin
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            timeout("resp_drain");
            sb.delete();
        end
    endtask

    vec_t vecs[11];

    initial begin
        bit ok;
        logic [15:0] cnt0;

        vecs[0]  = '{0, 4'h1, 8'h05, 8'h03, 8'h08, 1'b0};
        vecs[1]  = '{1, 4'h2, 8'h10, 8'h01, 8'h0F, 1'b0};
        vecs[2]  = '{0, 4'h4, 8'h13, 8'h24, 8'h0C, 1'b0};
        vecs[3]  = '{1, 4'h8, 8'h0B, 8'h00, 8'h02, 1'b0};
        vecs[4]  = '{1, 4'h3, 8'hAA, 8'hBB, 8'hFF, 1'b1};
        vecs[5]  = '{0, 4'h0, 8'h01, 8'h01, 8'hFF, 1'b1};
        vecs[6]  = '{0, 4'h1, 8'hFF, 8'h02, 8'h01, 1'b0};
        vecs[7]  = '{1, 4'h2, 8'h00, 8'h01, 8'hFF, 1'b0};
        vecs[8]  = '{0, 4'h4, 8'hFF, 8'hFF, 8'hE1, 1'b0};
        vecs[9]  = '{0, 4'hF, 8'h12, 8'h34, 8'hFF, 1'b1};
        vecs[10] = '{1, 4'h8, 8'hFF, 8'h00, 8'h00, 1'b0};

        rst_n          = 1'b0;
        bus.req_valid  = 2'b00;
        bus.req_opcode = '0;
        bus.req_num_1  = '0;
        bus.req_num_2  = '0;
        bus.resp_ready = 2'b11;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_resp_valid", {30'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_ans", {24'd0, bus.resp_ans}, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        chk("rst_alu_nums", {16'd0, alu_num_1, alu_num_2}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);

        // Table: each vector run to completion with the ALU opcode checked after accept
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ans, vecs[i].err);
            chk("alu_opcode_after_accept", {28'd0, alu_opcode}, vecs[i].err ? 32'd0 : {28'd0, vecs[i].op});
            chk("busy_after_accept", {31'd0, busy}, 32'd1);
            wait_done();
            chk("op_count_vec", {16'd0, op_count}, i + 1);
        end

        // Both requesters held valid: strict alternation starting with req0
        @(negedge clk);
        set_payload(0, 4'h2, 8'h10, 8'h01);
        set_payload(1, 4'h4, 8'h13, 8'h24);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            sb.push_back(mk_exp(k % 2, (k % 2) ? 8'h0C : 8'h0F, 1'b0));
            ok = 0;
            for (int n = 0; n < 30; n++) begin
                @(posedge clk);
                if ((bus.req_valid & bus.req_ready) != 2'b00) begin
                    ok = 1;
                    break;
                end
            end
            if (ok) chk("alt_grant", {30'd0, bus.req_ready}, (k % 2) ? 32'd2 : 32'd1);
            else timeout("alt_accept");
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        wait_done();
        chk("op_count_alt", {16'd0, op_count}, 32'd17);

        // Backpressure on req0; req1's ready bit must be ignored, req1 waits
        bus.resp_ready = 2'b10;
        issue(0, 4'h1, 8'h20, 8'h22, 8'h42, 1'b0);
        ok = 0;
        for (int n = 0; n < 10; n++) begin
            if (bus.resp_valid != 2'b00) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("bp_resp_valid");
        set_payload(1, 4'h1, 8'h01, 8'h01);
        bus.req_valid[1] = 1'b1;
        sb.push_back(mk_exp(1, 8'h02, 1'b0));
        cnt0 = op_count;
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_valid", {30'd0, bus.resp_valid}, 32'd1);
            chk("bp_resp_ans", {24'd0, bus.resp_ans}, 32'h42);
            chk("bp_req_ready", {30'd0, bus.req_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            chk("bp_op_count", {16'd0, op_count}, {16'd0, cnt0});
        end
        bus.resp_ready = 2'b11;
        ok = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            if (bus.req_ready[1]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("bp_req1_accept");
        @(negedge clk);
        bus.req_valid = 2'b00;
        wait_done();
        chk("bp_op_count_after", {16'd0, op_count}, {16'd0, cnt0} + 32'd2);

        // Reset during EXEC
        issue(0, 4'h1, 8'h01, 8'h02, 8'h03, 1'b0);
        chk("pre_rst_alu_opcode", {28'd0, alu_opcode}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        chk("midrst_resp_valid", {30'd0, bus.resp_valid}, 32'd0);
        chk("midrst_op_count", {16'd0, op_count}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 4'h1, 8'h04, 8'h04, 8'h08, 1'b0);
        wait_done();
        chk("post_rst_op_count", {16'd0, op_count}, 32'd1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
